// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared types and constants for the instruction-memory loader:
//                loader state encoding, header width and bytes-per-word helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

  // Loader states; CHK is only reachable when the checksum option is built in
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    CHK   = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } state_t;

  // Word-count header is always 16 bits, little-endian on the wire
  localparam int LEN_W = 16;

  // Default word width and the byte count it implies
  localparam int TAM_SALIDA_DEF = 32;
  localparam int BYTES_PER_WORD = TAM_SALIDA_DEF / 8;

  // Bytes per word for an arbitrary (multiple-of-8) word width
  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : imem_word_assembler
//  Description : Places incoming bytes little-endian into a word. Tracks the
//                byte index, flags the last byte of a word and exposes the
//                word as it will look once the current byte is merged.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_word_assembler
  import imem_pkg::*;
#(
  parameter int tam_salida = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_accept,
  input  logic [7:0]            i_byte,
  output logic                  o_last,
  output logic [tam_salida-1:0] o_word_next
);

  localparam int c_bpw   = bytes_per_word(tam_salida);
  localparam int c_idx_w = (c_bpw > 1) ? $clog2(c_bpw) : 1;
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(c_bpw - 1);
  localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

  logic [c_idx_w-1:0]    r_idx;
  logic [tam_salida-1:0] r_word;

  assign o_last = (r_idx == c_idx_last);

  // Merge the incoming byte into its lane so the caller can capture a full word
  always_comb begin
    o_word_next = r_word;
    o_word_next[{r_idx, 3'b000} +: 8] = i_byte;
  end

  // Byte index and partial word; index wraps to 0 after the last lane
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_accept) begin
      r_word <= o_word_next;
      r_idx  <= o_last ? '0 : r_idx + c_idx_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Instruction-memory writer. Takes a byte stream (16-bit word
//                count, then little-endian words), writes words to sequential
//                addresses from 0 and holds the core in reset while loading.
//                Optional trailing 8-bit checksum: IMEM_LOADER_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_pkg::*;
#(
  parameter int tam_entrada = 10,
  parameter int tam_salida  = 32
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   start,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   we,
  output logic [tam_entrada-1:0] waddr,
  output logic [tam_salida-1:0]  wdata,
  output logic                   busy,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   error
);

  localparam logic [tam_entrada:0] c_cnt_one = (tam_entrada+1)'(1);
  localparam logic [31:0]          c_depth   = 32'd1 << tam_entrada;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t c_st_final = CHK;
`else
  localparam state_t c_st_final = DONE;
`endif

  state_t                r_state;
  state_t                w_state_next;
  logic [LEN_W-1:0]      r_len;
  logic [tam_entrada:0]  r_wcnt;
  logic [tam_entrada:0]  w_wcnt_inc;
  logic [tam_entrada-1:0] r_waddr;
  logic [tam_salida-1:0] r_wdata;
  logic                  r_error;
  logic [LEN_W-1:0]      w_hdr;
  logic                  w_acc;
  logic                  w_start;
  logic                  w_last;
  logic [tam_salida-1:0] w_word_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            r_sum;
`endif

  assign w_acc      = rx_valid && rx_ready;
  assign w_start    = (r_state == IDLE) && start;
  assign w_hdr      = {rx_data, r_len[7:0]};
  assign w_wcnt_inc = r_wcnt + c_cnt_one;

  imem_word_assembler #(
    .tam_salida (tam_salida)
  ) u_asm (
    .clk         (CLK),
    .rst         (RESET),
    .i_clear     (w_start),
    .i_accept    ((r_state == DATA) && w_acc),
    .i_byte      (rx_data),
    .o_last      (w_last),
    .o_word_next (w_word_next)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode; every byte-consuming state waits on the handshake
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (start) w_state_next = LEN0;
      LEN0:  if (w_acc) w_state_next = LEN1;
      LEN1:  if (w_acc) begin
               if (w_hdr == '0)                 w_state_next = c_st_final;
               else if (32'(w_hdr) > c_depth)   w_state_next = ERR;
               else                             w_state_next = DATA;
             end
      DATA:  if (w_acc && w_last) w_state_next = WRITE;
      WRITE: w_state_next = (32'(w_wcnt_inc) == 32'(r_len)) ? c_st_final : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:   if (w_acc) w_state_next = (rx_data == r_sum) ? DONE : ERR;
`endif
      DONE:  w_state_next = IDLE;
      ERR:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    rx_ready = (r_state == LEN0) || (r_state == LEN1) || (r_state == DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    rx_ready = rx_ready || (r_state == CHK);
`endif
    we       = (r_state == WRITE);
    busy     = (r_state != IDLE);
    cpu_hold = busy;
    done     = (r_state == DONE);
    error    = r_error;
    waddr    = r_waddr;
    wdata    = r_wdata;
  end

  // Datapath: header, word counter, write port capture and sticky error
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_len   <= '0;
      r_wcnt  <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_start) begin
        r_len   <= '0;
        r_wcnt  <= '0;
        r_error <= 1'b0;
      end
      if ((r_state == LEN0) && w_acc) r_len[7:0]  <= rx_data;
      if ((r_state == LEN1) && w_acc) r_len[15:8] <= rx_data;
      // Capture address and completed word so they hold steady outside WRITE
      if ((r_state == DATA) && w_acc && w_last) begin
        r_waddr <= r_wcnt[tam_entrada-1:0];
        r_wdata <= w_word_next;
      end
      if (r_state == WRITE) r_wcnt <= w_wcnt_inc;
      if (w_state_next == ERR) r_error <= 1'b1;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running mod-256 sum of payload bytes
  always_ff @(posedge CLK) begin
    if (RESET || w_start)                 r_sum <= 8'h00;
    else if ((r_state == DATA) && w_acc)  r_sum <= r_sum + rx_data;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Expected writes are
//                queued as bytes are sent and popped when the DUT writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RESET, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, we, busy, cpu_hold, done, error;
  logic [9:0]  waddr;
  logic [31:0] wdata;

  int checks = 0, errors = 0, done_cnt = 0, we_cnt = 0;
  logic [41:0] sb[$];
  logic [41:0] mon_exp;
  logic [31:0] ld_words[8];

  imem_loader #(.tam_entrada(10), .tam_salida(32)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .we(we), .waddr(waddr),
    .wdata(wdata), .busy(busy), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 CLK = ~CLK;

  // Write monitor: each write must match the oldest queued expectation
  always @(negedge CLK) begin
    if (done === 1'b1) done_cnt++;
    if (we === 1'b1) begin
      we_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", waddr, wdata);
      end else begin
        mon_exp = sb.pop_front();
        if ({waddr, wdata} !== mon_exp) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                   waddr, wdata, mon_exp[41:32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    bit ok;
    for (int i = 0; i < 5 && $urandom_range(0, 99) < gap_pct; i++) tick();
    rx_data = b; rx_valid = 1'b1; ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge CLK);
      if (rx_ready === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL byte_timeout: rx_ready=%b, required 1", rx_ready);
    end
    @(posedge CLK); #1;
    rx_valid = 1'b0;
  endtask

  // Header plus n words from ld_words; expectations queued per word
  task automatic send_load(input logic [15:0] n, input int gap_pct, input bit bad_chk);
    logic [7:0] sum, b;
    sum = 8'h00;
    send_byte(n[7:0], gap_pct);
    send_byte(n[15:8], gap_pct);
    for (int w = 0; w < int'(n); w++) begin
      sb.push_back({10'(w), ld_words[w]});
      for (int k = 0; k < 4; k++) begin
        b = ld_words[w][8*k +: 8];
        sum = sum + b;
        send_byte(b, gap_pct);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_chk ? sum + 8'd1 : sum, gap_pct);
`else
    if (bad_chk) sum = sum + 8'd1;
`endif
  endtask

  task automatic wait_end(output bit got_done);
    bit fin;
    fin = 1'b0; got_done = 1'b0;
    for (int t = 0; t < 50 && !fin; t++) begin
      @(negedge CLK);
      if (done === 1'b1) begin fin = 1'b1; got_done = 1'b1; end
      else if (error === 1'b1) fin = 1'b1;
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL end_timeout: done=%b error=%b, required done or error", done, error);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick(); tick();
    checks++;
    if ({rx_ready, we, busy, cpu_hold, done, error} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, required 000000",
                         {rx_ready, we, busy, cpu_hold, done, error});
    end
    checks++;
    if (waddr !== 10'd0) begin errors++; $display("FAIL reset_waddr: got %0d, required 0", waddr); end
    checks++;
    if (wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h, required 0", wdata); end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_two_word();
    int d0, w0;
    bit gd;
    d0 = done_cnt; w0 = we_cnt;
    ld_words[0] = 32'h00000013; ld_words[1] = 32'h00100093;
    do_start();
    checks++;
    if ({busy, cpu_hold} !== 2'b11) begin
      errors++; $display("FAIL two_busy_start: got %b, required 11", {busy, cpu_hold});
    end
    send_load(16'd2, 0, 1'b0);
    wait_end(gd);
    checks++;
    if (!gd || error !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL two_done: got done=%b error=%b busy=%b, required 1 0 1", gd, error, busy);
    end
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL two_idle: got busy=%b hold=%b done=%b, required 0 0 0", busy, cpu_hold, done);
    end
    tick(); tick();
    checks++;
    if (done_cnt - d0 != 1 || we_cnt - w0 != 2) begin
      errors++; $display("FAIL two_counts: got done=%0d we=%0d, required 1 2", done_cnt - d0, we_cnt - w0);
    end
  endtask

  task automatic test_zero_len();
    int w0;
    w0 = we_cnt;
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL zero_done: got done=%b error=%b, required 1 0", done, error);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || we_cnt != w0) begin
      errors++; $display("FAIL zero_after: got busy=%b done=%b writes=%0d, required 0 0 0",
                         busy, done, we_cnt - w0);
    end
  endtask

  task automatic test_too_long();
    int w0;
    bit gd;
    w0 = we_cnt;
    do_start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    checks++;
    if (error !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL long_err: got error=%b done=%b, required 1 0", error, done);
    end
    tick(); tick();
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || we_cnt != w0) begin
      errors++; $display("FAIL long_sticky: got error=%b busy=%b writes=%0d, required 1 0 0",
                         error, busy, we_cnt - w0);
    end
    ld_words[0] = 32'hdeadbeef;
    do_start();
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL long_clear: got error=%b, required 0", error); end
    send_load(16'd1, 0, 1'b0);
    wait_end(gd);
    checks++;
    if (!gd) begin errors++; $display("FAIL long_reload: got done=%b, required 1", gd); end
    tick();
  endtask

  task automatic test_random_gaps();
    int w0;
    bit gd;
    w0 = we_cnt;
    for (int i = 0; i < 3; i++) ld_words[i] = $urandom;
    do_start();
    send_load(16'd3, 30, 1'b0);
    wait_end(gd);
    checks++;
    if (!gd || error !== 1'b0) begin
      errors++; $display("FAIL gaps_done: got done=%b error=%b, required 1 0", gd, error);
    end
    tick();
    checks++;
    if (we_cnt - w0 != 3) begin errors++; $display("FAIL gaps_writes: got %0d, required 3", we_cnt - w0); end
  endtask

  task automatic test_reset_mid();
    int w0;
    bit gd;
    w0 = we_cnt;
    do_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'haa, 0); send_byte(8'hbb, 0);
    RESET = 1'b1;
    tick();
    checks++;
    if ({rx_ready, we, busy, cpu_hold, done, error} !== 6'b0 || waddr !== 10'd0 || wdata !== 32'd0) begin
      errors++; $display("FAIL mid_reset: got ctrl=%b waddr=%0d wdata=%h, required 0 0 0",
                         {rx_ready, we, busy, cpu_hold, done, error}, waddr, wdata);
    end
    RESET = 1'b0;
    tick(); tick();
    checks++;
    if (we_cnt != w0) begin errors++; $display("FAIL mid_nowrite: got %0d writes, required 0", we_cnt - w0); end
    ld_words[0] = 32'h11223344; ld_words[1] = 32'h55667788;
    do_start();
    send_load(16'd2, 0, 1'b0);
    wait_end(gd);
    checks++;
    if (!gd || we_cnt - w0 != 2) begin
      errors++; $display("FAIL mid_reload: got done=%b writes=%0d, required 1 2", gd, we_cnt - w0);
    end
    tick();
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit gd;
    ld_words[0] = 32'h00000013;
    do_start();
    send_load(16'd1, 0, 1'b0);
    wait_end(gd);
    checks++;
    if (!gd || error !== 1'b0) begin
      errors++; $display("FAIL chk_good: got done=%b error=%b, required 1 0", gd, error);
    end
    tick();
    do_start();
    send_load(16'd1, 0, 1'b1);
    wait_end(gd);
    checks++;
    if (gd || error !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL chk_bad: got done=%b error=%b, required 0 1", gd, error);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_two_word();
    test_zero_len();
    test_too_long();
    test_random_gaps();
    test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    tick(); tick();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the core reads asynchronously.
- Receives a byte stream over a valid/ready handshake. The stream is a 16-bit word-count header followed by little-endian instruction bytes.
- Assembles the bytes into tam_salida-bit words and writes them to sequential addresses starting at 0.
- Holds the core in reset (cpu_hold) while a load is in progress.

Parameters:
- tam_entrada, 10, address width; memory depth is 2^tam_entrada words.
- tam_salida, 32, word width; must be a multiple of 8, giving tam_salida/8 bytes per word.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- we  out  1  memory write enable, one-cycle pulse per word.
- waddr  out  tam_entrada  memory write address.
- wdata  out  tam_salida  memory write data.
- busy  out  1  load in progress.
- cpu_hold  out  1  equals busy; keeps the core in reset.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset: state IDLE. rx_ready, we, busy, cpu_hold, done, error are 0. waddr, wdata, word counter, byte index and length register are 0.
- Byte transfer: occurs on a cycle with rx_valid && rx_ready. rx_ready is 1 only in LEN0, LEN1, DATA (and CHK when enabled).
- IDLE: start=1 → LEN0. On the same edge, error clears, busy goes to 1 and the counters clear. start is ignored in every other state.
- LEN0: accepted byte → len[7:0], then LEN1.
- LEN1: accepted byte → len[15:8], then evaluate:
  - len == 0 → DONE.
  - len > 2^tam_entrada → ERR.
  - otherwise → DATA.
- DATA: accepted byte at index k (0..tam_salida/8-1) is placed in wdata[8k+7:8k]; k increments. After the last byte of a word → WRITE, with no further byte accepted that cycle.
- WRITE: one cycle, we=1, waddr=word counter, wdata=assembled word. Word counter increments.
  - If new counter == len → DONE (or CHK when enabled).
  - Otherwise → DATA with k=0.
- DONE: one cycle, done=1, busy=0 from the next cycle, → IDLE.
- ERR: one cycle, error=1 (stays high in IDLE), busy=0 from the next cycle, → IDLE. No further writes occur.
- Timing: minimum 5 cycles per word (4 bytes + 1 write cycle) with rx_valid held high. Counter width is tam_entrada+1 so that len = 2^tam_entrada terminates correctly.
- we is 0 in every state except WRITE. waddr/wdata hold their last values outside WRITE.
- Backpressure: rx_valid low stalls in the current state with no side effects.
- RESET mid-load: returns to IDLE next edge. Partial word is discarded, no write issues, error=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of all DATA bytes is kept; it clears on start.
  - After the final WRITE, the block enters CHK and accepts one byte.
  - Byte equal to the sum → DONE. Otherwise → ERR; words already written remain in memory.
  - len == 0 goes through CHK, where the expected value is 0x00.
- Not defined: no CHK state, no sum register; the final WRITE goes directly to DONE.

Decomposition:
- Package imem_pkg:
  - State enum: IDLE, LEN0, LEN1, DATA, WRITE, CHK, DONE, ERR.
  - Constant BYTES_PER_WORD = tam_salida/8.
  - Header width constant LEN_W = 16.
- Sub-module imem_word_assembler: byte index counter plus shift/place into wdata, with clear and accept inputs. Used by imem_loader.

Test Plan:
- Reset, then start; bytes 02 00 | 13 00 00 00 | 93 00 10 00 → we pulses at waddr 0 with wdata 0x00000013, then at waddr 1 with 0x00100093; done pulses once; error=0; busy high from start until done.
- Header 00 00 → no we, done pulses 1 cycle after LEN1 byte; busy=0 afterwards.
- Header for tam_entrada=10: 01 04 (len=1025) → ERR, error=1 sticky, no we. Next start clears error.
- Random rx_valid gaps (30% idle) on a 3-word load → identical waddr/wdata sequence; no byte is lost or duplicated.
- RESET asserted after 2 data bytes of word 0 → no we, all outputs 0. A new full load afterwards writes correctly from waddr 0.
- With IMEM_LOADER_CHECKSUM_EN: 1 word 13 00 00 00, checksum 0x13 → done. Checksum 0x14 → error=1, done=0; word is still written at waddr 0.
